// File: rtl/rmt_ingress_classifier_if.sv
// -----------------------------------------------------------------------------
// rmt_ingress_classifier_if
// One AXI-Stream link (data, byte enables, user sideband, valid/ready, last).
//   master modport : drives tdata/tkeep/tuser/tvalid/tlast, receives tready
//   slave modport  : receives tdata/tkeep/tuser/tvalid/tlast, drives tready
// -----------------------------------------------------------------------------
interface rmt_ingress_classifier_if #(
  parameter int DATA_WIDTH  = 512,
  parameter int TUSER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/rmt_ingress_classifier.sv
// -----------------------------------------------------------------------------
// rmt_ingress_classifier
// Inspects the first beat of every packet and steers the whole packet to the
// control path (UDP reconfiguration), the data path (VLAN traffic) or drops it
// (non-VLAN). One shared output register gives one cycle of latency.
//
// Ports:
//   clk          stream clock
//   aresetn      synchronous active-low reset
//   s_axis       input stream (slave)
//   m_axis       data path towards rmt_wrapper (master)
//   c_m_axis     control path towards the RMT config chain (master)
//   data_pkt_cnt saturating count of data packets accepted
//   ctrl_pkt_cnt saturating count of control packets accepted
//   drop_pkt_cnt saturating count of packets dropped
// -----------------------------------------------------------------------------
module rmt_ingress_classifier #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] CTRL_UDP_PORT        = 16'hf1f2,
  parameter int          CNT_WIDTH            = 32
) (
  input  logic                           clk,
  input  logic                           aresetn,
  rmt_ingress_classifier_if.slave        s_axis,
  rmt_ingress_classifier_if.master       m_axis,
  rmt_ingress_classifier_if.master       c_m_axis,
  output logic [CNT_WIDTH-1:0]           data_pkt_cnt,
  output logic [CNT_WIDTH-1:0]           ctrl_pkt_cnt,
  output logic [CNT_WIDTH-1:0]           drop_pkt_cnt
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FWD_DATA = 2'd1;
  localparam logic [1:0] ST_FWD_CTRL = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

  localparam logic [1:0] CLS_DATA = 2'd0;
  localparam logic [1:0] CLS_CTRL = 2'd1;
  localparam logic [1:0] CLS_DROP = 2'd2;

  localparam logic DST_DATA = 1'b0;
  localparam logic DST_CTRL = 1'b1;

  // Header fields are taken from raw bytes regardless of tkeep; each field is
  // in network order, so the lower-numbered byte is the high half.
  function automatic logic [1:0] classify(input logic [15:0] etype,
                                          input logic [15:0] l3type,
                                          input logic [7:0]  proto,
                                          input logic [15:0] dport);
    logic is_vlan;
    is_vlan = (etype == 16'h8100);
    if (is_vlan && (l3type == 16'h0800) && (proto == 8'h11) && (dport == CTRL_UDP_PORT)) begin
      classify = CLS_CTRL;
    end else if (is_vlan) begin
      classify = CLS_DATA;
    end else begin
      classify = CLS_DROP;
    end
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [1:0]                          r_state;
  logic                                r_out_valid;
  logic                                r_dst;
  logic [C_S_AXIS_DATA_WIDTH-1:0]      r_tdata;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    r_tkeep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]     r_tuser;
  logic                                r_tlast;
  logic [CNT_WIDTH-1:0]                r_data_cnt;
  logic [CNT_WIDTH-1:0]                r_ctrl_cnt;
  logic [CNT_WIDTH-1:0]                r_drop_cnt;

  logic [1:0] w_first_cls;
  logic [1:0] w_cur_cls;
  logic [1:0] w_next_state;
  logic       w_sel_ready;
  logic       w_drain;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_load;
  logic       w_first_acc;

  assign w_first_cls = classify({s_axis.tdata[103:96],  s_axis.tdata[111:104]},
                                {s_axis.tdata[135:128], s_axis.tdata[143:136]},
                                s_axis.tdata[223:216],
                                {s_axis.tdata[327:320], s_axis.tdata[335:328]});

  // Class of the beat on the input: fresh decode in IDLE, locked otherwise.
  always_comb begin
    w_cur_cls = CLS_DROP;
    case (r_state)
      ST_IDLE:     w_cur_cls = w_first_cls;
      ST_FWD_DATA: w_cur_cls = CLS_DATA;
      ST_FWD_CTRL: w_cur_cls = CLS_CTRL;
      ST_DROP:     w_cur_cls = CLS_DROP;
      default:     w_cur_cls = CLS_DROP;
    endcase
  end

  // Only the port the held beat is destined for can drain the register.
  assign w_sel_ready = (r_dst == DST_CTRL) ? c_m_axis.tready : m_axis.tready;
  assign w_drain     = r_out_valid & w_sel_ready;

  // Dropped beats bypass the register, so they are always accepted.
  always_comb begin
    w_in_ready = 1'b0;
    if (!aresetn) begin
      w_in_ready = 1'b0;
    end else if (w_cur_cls == CLS_DROP) begin
      w_in_ready = 1'b1;
    end else begin
      w_in_ready = !r_out_valid | w_drain;
    end
  end

  assign w_accept    = s_axis.tvalid & w_in_ready;
  assign w_load      = w_accept & (w_cur_cls != CLS_DROP);
  assign w_first_acc = w_accept & (r_state == ST_IDLE);

  // Packet FSM: a single-beat packet never leaves IDLE.
  always_comb begin
    w_next_state = r_state;
    if (w_accept) begin
      if (s_axis.tlast) begin
        w_next_state = ST_IDLE;
      end else if (r_state == ST_IDLE) begin
        case (w_first_cls)
          CLS_CTRL: w_next_state = ST_FWD_CTRL;
          CLS_DATA: w_next_state = ST_FWD_DATA;
          default:  w_next_state = ST_DROP;
        endcase
      end else begin
        w_next_state = r_state;
      end
    end else begin
      w_next_state = r_state;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Shared output register; a load in the drain cycle keeps valid high.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_out_valid <= 1'b0;
      r_dst       <= DST_DATA;
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tuser     <= '0;
      r_tlast     <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_dst       <= (w_cur_cls == CLS_CTRL) ? DST_CTRL : DST_DATA;
      r_tdata     <= s_axis.tdata;
      r_tkeep     <= s_axis.tkeep;
      r_tuser     <= s_axis.tuser;
      r_tlast     <= s_axis.tlast;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Per-class packet counters, bumped on the accepted first beat.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_data_cnt <= '0;
      r_ctrl_cnt <= '0;
      r_drop_cnt <= '0;
    end else if (w_first_acc) begin
      case (w_first_cls)
        CLS_DATA: r_data_cnt <= sat_inc(r_data_cnt);
        CLS_CTRL: r_ctrl_cnt <= sat_inc(r_ctrl_cnt);
        default:  r_drop_cnt <= sat_inc(r_drop_cnt);
      endcase
    end else begin
      r_data_cnt <= r_data_cnt;
    end
  end

  assign s_axis.tready = w_in_ready;

  assign m_axis.tdata    = r_tdata;
  assign m_axis.tkeep    = r_tkeep;
  assign m_axis.tuser    = r_tuser;
  assign m_axis.tlast    = r_tlast;
  assign m_axis.tvalid   = r_out_valid & (r_dst == DST_DATA);

  assign c_m_axis.tdata  = r_tdata;
  assign c_m_axis.tkeep  = r_tkeep;
  assign c_m_axis.tuser  = r_tuser;
  assign c_m_axis.tlast  = r_tlast;
  assign c_m_axis.tvalid = r_out_valid & (r_dst == DST_CTRL);

  assign data_pkt_cnt = r_data_cnt;
  assign ctrl_pkt_cnt = r_ctrl_cnt;
  assign drop_pkt_cnt = r_drop_cnt;

endmodule

// File: tb/tb_rmt_ingress_classifier.sv
// -----------------------------------------------------------------------------
// tb_rmt_ingress_classifier
// Directed bench for rmt_ingress_classifier. Beats expected on each output are
// queued when the input handshake happens and compared as they drain. Counters
// are built 4 bits wide here so that saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_rmt_ingress_classifier;

  localparam int CW = 4;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  rmt_ingress_classifier_if s_if ();
  rmt_ingress_classifier_if m_if ();
  rmt_ingress_classifier_if c_if ();

  logic [CW-1:0] data_cnt, ctrl_cnt, drop_cnt;

  rmt_ingress_classifier #(
    .C_S_AXIS_DATA_WIDTH (512),
    .C_S_AXIS_TUSER_WIDTH(128),
    .CTRL_UDP_PORT       (16'hf1f2),
    .CNT_WIDTH           (CW)
  ) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .c_m_axis    (c_if),
    .data_pkt_cnt(data_cnt),
    .ctrl_pkt_cnt(ctrl_cnt),
    .drop_pkt_cnt(drop_cnt)
  );

  beat_t exp_m_q[$];
  beat_t exp_c_q[$];
  beat_t em, ec;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Header builder: etype at bytes 12-13, L3 type 16-17, proto 27, dport 40-41.
  function automatic beat_t mk(input logic [15:0] etype, input logic [15:0] l3,
                               input logic [7:0] proto, input logic [15:0] dport,
                               input logic [63:0] keep, input logic last);
    beat_t b;
    for (int i = 0; i < 16; i++) b.d[32*i +: 32] = $urandom;
    for (int i = 0; i < 4; i++) b.u[32*i +: 32] = $urandom;
    b.d[8*12 +: 8] = etype[15:8];
    b.d[8*13 +: 8] = etype[7:0];
    b.d[8*14 +: 8] = 8'h00;
    b.d[8*15 +: 8] = 8'h0f;
    b.d[8*16 +: 8] = l3[15:8];
    b.d[8*17 +: 8] = l3[7:0];
    b.d[8*27 +: 8] = proto;
    b.d[8*40 +: 8] = dport[15:8];
    b.d[8*41 +: 8] = dport[7:0];
    b.k = keep;
    b.l = last;
    return b;
  endfunction

  // Output scoreboard: every accepted output beat must match the queue head.
  always @(negedge clk) begin
    if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
      if (exp_m_q.size() == 0) begin
        chk("m_unexpected_beat", {511'd0, m_if.tvalid}, 512'd0);
      end else begin
        em = exp_m_q.pop_front();
        chk("m_tdata", m_if.tdata, em.d);
        chk("m_tkeep", {448'd0, m_if.tkeep}, {448'd0, em.k});
        chk("m_tuser", {384'd0, m_if.tuser}, {384'd0, em.u});
        chk("m_tlast", {511'd0, m_if.tlast}, {511'd0, em.l});
      end
    end
    if (c_if.tvalid === 1'b1 && c_if.tready === 1'b1) begin
      if (exp_c_q.size() == 0) begin
        chk("c_unexpected_beat", {511'd0, c_if.tvalid}, 512'd0);
      end else begin
        ec = exp_c_q.pop_front();
        chk("c_tdata", c_if.tdata, ec.d);
        chk("c_tkeep", {448'd0, c_if.tkeep}, {448'd0, ec.k});
        chk("c_tuser", {384'd0, c_if.tuser}, {384'd0, ec.u});
        chk("c_tlast", {511'd0, c_if.tlast}, {511'd0, ec.l});
      end
    end
  end

  // Presents one beat from posedge+1 and returns at posedge+1 after its
  // handshake. dst: 0 data, 1 ctrl, 2 drop. pm/pc >= 0 check the output valids
  // at the first negedge (i.e. the result of the previous handshake).
  task automatic send_beat(input beat_t b, input int dst, input bit need_ready,
                           input int pm, input int pc, input string tag);
    int waited = 0;
    s_if.tdata  = b.d;
    s_if.tkeep  = b.k;
    s_if.tuser  = b.u;
    s_if.tlast  = b.l;
    s_if.tvalid = 1'b1;
    @(negedge clk);
    if (pm >= 0) chk({tag, "_prev_m_valid"}, {511'd0, m_if.tvalid}, pm[511:0]);
    if (pc >= 0) chk({tag, "_prev_c_valid"}, {511'd0, c_if.tvalid}, pc[511:0]);
    if (need_ready) chk({tag, "_ready"}, {511'd0, s_if.tready}, 512'd1);
    while (s_if.tready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      chk({tag, "_timeout"}, {511'd0, s_if.tready}, 512'd1);
    end else if (dst == 0) begin
      exp_m_q.push_back(b);
    end else if (dst == 1) begin
      exp_c_q.push_back(b);
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic check_after(input logic mv, input logic cv, input string tag);
    @(negedge clk);
    chk({tag, "_m_valid"}, {511'd0, m_if.tvalid}, {511'd0, mv});
    chk({tag, "_c_valid"}, {511'd0, c_if.tvalid}, {511'd0, cv});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b0, b1, b2;
    logic [CW-1:0] exp_data;
    s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    c_if.tready = 1'b1;

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", {511'd0, s_if.tready}, 512'd0);
    chk("rst_m_valid", {511'd0, m_if.tvalid}, 512'd0);
    chk("rst_c_valid", {511'd0, c_if.tvalid}, 512'd0);
    chk("rst_m_tdata", m_if.tdata, 512'd0);
    chk("rst_counts", {500'd0, data_cnt, ctrl_cnt, drop_cnt}, 512'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", {511'd0, s_if.tready}, 512'd1);
    @(posedge clk); #1;

    // Control packet, two beats
    b0 = mk(16'h8100, 16'h0800, 8'h11, 16'hf1f2, 64'hffffffffffffffff, 1'b0);
    b1 = mk(16'h0800, 16'h1234, 8'h06, 16'h0000, 64'h00000000000fffff, 1'b1);
    send_beat(b0, 1, 1'b1, -1, -1, "ctrl_b0");
    send_beat(b1, 1, 1'b1, 0, 1, "ctrl_b1");
    check_after(1'b0, 1'b1, "ctrl_b1_out");
    chk("ctrl_cnt_1", {508'd0, ctrl_cnt}, 512'd1);

    // Single-beat data packet that almost matches the control pattern
    b0 = mk(16'h8100, 16'h0800, 8'h11, 16'h10e1, 64'hffffffffffffffff, 1'b1);
    send_beat(b0, 0, 1'b1, -1, -1, "data1");
    check_after(1'b1, 1'b0, "data1_out");
    chk("data_cnt_1", {508'd0, data_cnt}, 512'd1);

    // Non-VLAN frame: three beats dropped; later beats carry VLAN/control patterns
    b0 = mk(16'h0800, 16'h0800, 8'h11, 16'hf1f2, 64'hffffffffffffffff, 1'b0);
    b1 = mk(16'h8100, 16'h0800, 8'h11, 16'hf1f2, 64'hffffffffffffffff, 1'b0);
    b2 = mk(16'h8100, 16'h0800, 8'h06, 16'h1111, 64'h00000000000000ff, 1'b1);
    send_beat(b0, 2, 1'b1, 0, 0, "drop_b0");
    send_beat(b1, 2, 1'b1, 0, 0, "drop_b1");
    send_beat(b2, 2, 1'b1, 0, 0, "drop_b2");
    check_after(1'b0, 1'b0, "drop_out");
    chk("drop_cnt_1", {508'd0, drop_cnt}, 512'd1);
    chk("drop_data_cnt", {508'd0, data_cnt}, 512'd1);

    // Backpressure on the data path for 5 cycles during a 3-beat packet
    m_if.tready = 1'b0;
    b0 = mk(16'h8100, 16'h86dd, 8'h3a, 16'h0001, 64'hffffffffffffffff, 1'b0);
    b1 = mk(16'h8100, 16'h0800, 8'h11, 16'hf1f2, 64'hffffffffffffffff, 1'b0);
    b2 = mk(16'h0800, 16'h0000, 8'h00, 16'h0000, 64'h000000000000ffff, 1'b1);
    send_beat(b0, 0, 1'b1, -1, -1, "bp_b0");
    s_if.tdata = b1.d; s_if.tkeep = b1.k; s_if.tuser = b1.u; s_if.tlast = b1.l;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_s_ready_low", {511'd0, s_if.tready}, 512'd0);
      chk("bp_m_valid_held", {511'd0, m_if.tvalid}, 512'd1);
      chk("bp_m_tdata_stable", m_if.tdata, b0.d);
    end
    @(posedge clk); #1;
    m_if.tready = 1'b1;
    send_beat(b1, 0, 1'b1, -1, -1, "bp_b1");
    send_beat(b2, 0, 1'b1, 1, 0, "bp_b2");
    check_after(1'b1, 1'b0, "bp_out");
    chk("bp_data_cnt", {508'd0, data_cnt}, 512'd2);
    chk("bp_m_q_empty", exp_m_q.size(), 512'd0);

    // Back-to-back control then data packets, no bubbles
    b0 = mk(16'h8100, 16'h0800, 8'h11, 16'hf1f2, 64'hffffffffffffffff, 1'b0);
    b1 = mk(16'h0800, 16'h0000, 8'h00, 16'h0000, 64'h0000ffffffffffff, 1'b1);
    send_beat(b0, 1, 1'b1, -1, -1, "b2b_c0");
    send_beat(b1, 1, 1'b1, 0, 1, "b2b_c1");
    b0 = mk(16'h8100, 16'h0800, 8'h11, 16'hf1f3, 64'hffffffffffffffff, 1'b0);
    b1 = mk(16'h8100, 16'h0800, 8'h11, 16'hf1f2, 64'h00000000ffffffff, 1'b1);
    send_beat(b0, 0, 1'b1, 0, 1, "b2b_d0");
    send_beat(b1, 0, 1'b1, 1, 0, "b2b_d1");
    check_after(1'b1, 1'b0, "b2b_out");
    chk("b2b_ctrl_cnt", {508'd0, ctrl_cnt}, 512'd2);
    chk("b2b_data_cnt", {508'd0, data_cnt}, 512'd3);

    // Saturation of the data counter
    exp_data = 4'd3;
    for (int i = 0; i < 12; i++) begin
      b0 = mk(16'h8100, 16'h0800, 8'h06, 16'h0050, 64'hffffffffffffffff, 1'b1);
      send_beat(b0, 0, 1'b1, -1, -1, "sat_pkt");
      if (exp_data != 4'hf) exp_data = exp_data + 4'd1;
    end
    check_after(1'b1, 1'b0, "sat_out");
    chk("sat_cnt_full", {508'd0, data_cnt}, {508'd0, exp_data});
    b0 = mk(16'h8100, 16'h0800, 8'h06, 16'h0050, 64'hffffffffffffffff, 1'b1);
    send_beat(b0, 0, 1'b1, -1, -1, "sat_extra");
    check_after(1'b1, 1'b0, "sat_extra_out");
    chk("sat_cnt_hold", {508'd0, data_cnt}, 512'hf);

    // Reset in the middle of a data packet
    b0 = mk(16'h8100, 16'h0800, 8'h06, 16'h0050, 64'hffffffffffffffff, 1'b0);
    send_beat(b0, 0, 1'b1, -1, -1, "mid_b0");
    aresetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_s_ready", {511'd0, s_if.tready}, 512'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    chk("mid_rst_m_valid", {511'd0, m_if.tvalid}, 512'd0);
    chk("mid_rst_c_valid", {511'd0, c_if.tvalid}, 512'd0);
    chk("mid_rst_tlast", {510'd0, m_if.tlast, c_if.tlast}, 512'd0);
    chk("mid_rst_tdata", m_if.tdata, 512'd0);
    chk("mid_rst_tkeep_tuser", {320'd0, m_if.tkeep, m_if.tuser}, 512'd0);
    chk("mid_rst_counts", {500'd0, data_cnt, ctrl_cnt, drop_cnt}, 512'd0);
    @(posedge clk); #1;
    b1 = mk(16'h8100, 16'h0800, 8'h11, 16'hf1f2, 64'hffffffffffffffff, 1'b1);
    send_beat(b1, 1, 1'b1, -1, -1, "post_rst");
    check_after(1'b0, 1'b1, "post_rst_out");
    chk("post_rst_ctrl_cnt", {508'd0, ctrl_cnt}, 512'd1);
    chk("post_rst_data_cnt", {508'd0, data_cnt}, 512'd0);

    repeat (2) @(posedge clk);
    chk("final_m_q_empty", exp_m_q.size(), 512'd0);
    chk("final_c_q_empty", exp_c_q.size(), 512'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
